sid_mixer_dac: RTL and testbench
================================

// Module: sid_mixer_dac
// PURPOSE
//  Output stage downstream of the three-voice SID tone/envelope generator.
//  - Sums the three 12-bit voice samples, honouring the 3OFF mute bit.
//  - Scales the sum by the 4-bit master volume.
//  - Publishes a 16-bit mixed sample and drives a 1-bit audio pin (delta-sigma or PWM) for an external RC filter.
//  - Register values (mode_vol) come from the SID register file; the filter bits in that register are ignored here.
// PARAMETERS
//  PWM_W     8    PWM counter width; the PWM compare uses mix_out[15:16-PWM_W]
// PORTS
//  clk         in   1   system clock
//  rst_n       in   1   asynchronous, active-low reset
//  clk_enable  in   1   SID tick; the same enable that drives the voice generator
//  sample1     in   12  voice 1 sample (post-envelope)
//  sample2     in   12  voice 2 sample
//  sample3     in   12  voice 3 sample
//  mode_vol    in   8   SID reg 0x18: [7]=3OFF, [3:0]=master volume, [6:4] ignored
//  dac_mode    in   1   0 = first-order delta-sigma, 1 = PWM
//  mix_out     out  16  scaled mix, held between updates
//  mix_valid   out  1   one-clk pulse when mix_out has just updated
//  dac_out     out  1   1-bit audio output
// BEHAVIOUR
//  Reset (async, rst_n=0):
//   - phase, acc, mix_out, err, pwm_cnt cleared; mix_valid=0, dac_out=0.
//   - Takes effect immediately, mid-accumulation included; the partial sum is discarded.
//  Mix sequencer: 2-bit phase counter, advances only on clk_enable=1 and wraps 3->0.
//   - ph0: acc <= {2'b0,sample1}
//   - ph1: acc <= acc + sample2
//   - ph2: acc <= acc + (mode_vol[7] ? 0 : sample3); 3OFF is sampled in ph2 only
//   - ph3: scaled = acc(14b) * mode_vol[3:0] (18b, max 184275); mix_out <= scaled[17:2];
//     mix_valid <= 1 for exactly one clk. Volume is sampled in ph3 only.
//  Timing and widths:
//   - Latency: mix_out reflects sample1 captured 3 enables earlier; one new mix per 4 enables.
//   - acc is 14 bits (max 3*4095 = 12285), so no overflow. Volume 0 gives mix_out=0 with mix_valid still pulsed.
//   - clk_enable=0: phase, acc and mix_out hold; mix_valid stays 0.
//  DAC (runs every clk, independent of clk_enable):
//   - Delta-sigma: {c,err} <= err + mix_out (17-bit add), dac_out <= c.
//     mix_out=0 gives constant 0; 0xFFFF gives 1 on all but one clk in 65536.
//   - PWM: pwm_cnt free-runs mod 2^PWM_W; dac_out <= (pwm_cnt < mix_out[15:16-PWM_W]).
//   - dac_mode change (registered edge detect): err and pwm_cnt forced to 0 on the next clk; dac_out=0 that clk.
//   - mix_out updating mid-PWM-period: the new compare value is used from the next clk (no double buffering).
// STRUCTURE
//  Package sid_pkg:
//   - SAMPLE_W=12, ACC_W=14, MIX_W=16, VOL_W=4
//   - phase localparams PH_V1..PH_SCALE
//   - MODE_VOL bit indices (3OFF=7, VOL=3:0)
//  Sub-module sid_dsm: the DAC (delta-sigma + PWM + mode-change clear), taking mix_out and dac_mode.
//  Top level holds the sequencer and the multiplier.
// TESTING
//  1. All samples 0xFFF, vol=15, 3OFF=0, clk_enable every clk -> mix_out=0xB3F4, mix_valid once per 4 clks.
//  2. Same with 3OFF=1 -> mix_out=0x77F8. Toggling 3OFF during ph0/ph1 still applies it; toggling after ph2 affects only the next mix.
//  3. vol=0 with any samples -> mix_out=0, dac_out constant 0 in both modes.
//  4. Delta-sigma, mix_out forced to 0x8000 -> dac_out 0,1,0,1... after reset.
//     mix_out=0x4000 -> exactly 1 high per 4 clks.
//  5. PWM, mix_out[15:8]=0x40 -> dac_out high for 64 of every 256 clks.
//     Switching dac_mode mid-period -> counter restarts from 0.
//  6. rst_n pulsed low between ph1 and ph2, and clk_enable gapped randomly -> all outputs 0 asynchronously.
//     The first mix after release uses a fresh ph0 and matches the reference model.

Source files
------------

// File: rtl/sid_pkg.sv
// Shared widths, sequencer phases and register bit positions for the SID output stage.
package sid_pkg;

  localparam int SAMPLE_W = 12;
  localparam int ACC_W    = 14;
  localparam int MIX_W    = 16;
  localparam int VOL_W    = 4;
  localparam int SCALED_W = ACC_W + VOL_W;

  localparam logic [1:0] PH_V1    = 2'd0;
  localparam logic [1:0] PH_V2    = 2'd1;
  localparam logic [1:0] PH_V3    = 2'd2;
  localparam logic [1:0] PH_SCALE = 2'd3;

  localparam int MV_3OFF   = 7;
  localparam int MV_VOL_HI = 3;
  localparam int MV_VOL_LO = 0;

  // The 18-bit product is dropped by two bits so full scale (184275) fits the 16-bit mix.
  function automatic logic [MIX_W-1:0] scale_mix(input logic [ACC_W-1:0] acc,
                                                 input logic [VOL_W-1:0] vol);
    logic [SCALED_W-1:0] scaled;
    scaled = SCALED_W'(acc) * SCALED_W'(vol);
    return scaled[SCALED_W-1:2];
  endfunction

endpackage

// File: rtl/sid_dsm.sv
// 1-bit audio DAC: first-order delta-sigma or PWM, with counter/error clear on a mode change.
module sid_dsm
  import sid_pkg::*;
#(
  parameter int PWM_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [MIX_W-1:0] mix,
  input  logic             dac_mode,
  output logic             dac_out
);

  logic             mode_q;
  logic [MIX_W-1:0] err;
  logic [PWM_W-1:0] pwm_cnt;
  logic [MIX_W:0]   ds_sum;

  assign ds_sum = {1'b0, err} + {1'b0, mix};

  // The PWM compare reads mix directly, so a new mix takes effect on the very next clock.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mode_q  <= 1'b0;
      err     <= '0;
      pwm_cnt <= '0;
      dac_out <= 1'b0;
    end else begin
      mode_q <= dac_mode;
      if (dac_mode != mode_q) begin
        err     <= '0;
        pwm_cnt <= '0;
        dac_out <= 1'b0;
      end else begin
        pwm_cnt <= pwm_cnt + 1'b1;
        if (!dac_mode) begin
          {dac_out, err} <= ds_sum;
        end else begin
          dac_out <= (pwm_cnt < mix[MIX_W-1 -: PWM_W]);
        end
      end
    end
  end

endmodule

// File: rtl/sid_mixer_dac.sv
// SID output stage: sums the three voices over four clk_enable ticks, applies master
// volume, and hands the 16-bit mix to the 1-bit DAC.
module sid_mixer_dac
  import sid_pkg::*;
#(
  parameter int PWM_W = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                clk_enable,
  input  logic [SAMPLE_W-1:0] sample1,
  input  logic [SAMPLE_W-1:0] sample2,
  input  logic [SAMPLE_W-1:0] sample3,
  input  logic [7:0]          mode_vol,
  input  logic                dac_mode,
  output logic [MIX_W-1:0]    mix_out,
  output logic                mix_valid,
  output logic                dac_out
);

  logic [1:0]       phase;
  logic [ACC_W-1:0] acc;
  logic [ACC_W-1:0] v3_term;

  assign v3_term = mode_vol[MV_3OFF] ? '0 : ACC_W'(sample3);

  // 3OFF is looked at only in PH_V3 and volume only in PH_SCALE, matching when the
  // voice generator's register writes are meant to land.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      phase     <= PH_V1;
      acc       <= '0;
      mix_out   <= '0;
      mix_valid <= 1'b0;
    end else begin
      mix_valid <= 1'b0;
      if (clk_enable) begin
        phase <= phase + 2'd1;
        case (phase)
          PH_V1:    acc <= ACC_W'(sample1);
          PH_V2:    acc <= acc + ACC_W'(sample2);
          PH_V3:    acc <= acc + v3_term;
          PH_SCALE: begin
            mix_out   <= scale_mix(acc, mode_vol[MV_VOL_HI:MV_VOL_LO]);
            mix_valid <= 1'b1;
          end
          default:  acc <= acc;
        endcase
      end
    end
  end

  sid_dsm #(
    .PWM_W(PWM_W)
  ) u_dsm (
    .clk      (clk),
    .rst_n    (rst_n),
    .mix      (mix_out),
    .dac_mode (dac_mode),
    .dac_out  (dac_out)
  );

endmodule

// File: tb/tb_sid_mixer_dac.sv
// Randomized bench for sid_mixer_dac against a transaction-level mixer model and a
// per-clock arithmetic model of the delta-sigma / PWM output.
module tb_sid_mixer_dac;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        clk_enable;
  logic [11:0] sample1, sample2, sample3;
  logic [7:0]  mode_vol;
  logic        dac_mode;
  logic [15:0] mix_out;
  logic        mix_valid;
  logic        dac_out;

  always #5 clk = ~clk;

  sid_mixer_dac #(
    .PWM_W(8)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .clk_enable (clk_enable),
    .sample1    (sample1),
    .sample2    (sample2),
    .sample3    (sample3),
    .mode_vol   (mode_vol),
    .dac_mode   (dac_mode),
    .mix_out    (mix_out),
    .mix_valid  (mix_valid),
    .dac_out    (dac_out)
  );

  typedef struct {
    int s1;
    int s2;
    int s3;
    int mv;
  } tick_t;

  tick_t ticks[$];
  int mixM, validM, dacM, errM, cntM, modePrevM;
  int errors = 0;
  int checks = 0;
  int dacHighs, validCount;
  int curMode = 0;

  task automatic checkOutput(input string tag, input int got, input int want);
    checks++;
    if (got != want) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d at %0t", tag, got, want, $time);
    end
  endtask

  task automatic resetModel();
    ticks.delete();
    mixM = 0; validM = 0; dacM = 0; errM = 0; cntM = 0; modePrevM = 0;
  endtask

  // One mix is built from four consecutive enable ticks: voice 1 of the first, voice 2 of
  // the second, voice 3 (unless muted) of the third, volume of the fourth.
  task automatic modelEdge();
    int oldMix, sum, vol, s;
    oldMix = mixM;
    validM = 0;
    if (clk_enable) begin
      ticks.push_back('{int'(sample1), int'(sample2), int'(sample3), int'(mode_vol)});
      if (ticks.size() == 4) begin
        sum = ticks[0].s1 + ticks[1].s2 + ((ticks[2].mv / 128) % 2 == 1 ? 0 : ticks[2].s3);
        vol = ticks[3].mv % 16;
        mixM = (sum * vol) / 4;
        validM = 1;
        ticks.delete();
      end
    end
    if (int'(dac_mode) != modePrevM) begin
      errM = 0; cntM = 0; dacM = 0;
    end else begin
      if (dac_mode == 1'b0) begin
        s = errM + oldMix;
        dacM = s / 65536;
        errM = s % 65536;
      end else begin
        dacM = (cntM < oldMix / 256) ? 1 : 0;
      end
      cntM = (cntM + 1) % 256;
    end
    modePrevM = int'(dac_mode);
  endtask

  task automatic applyStimulus(input int s1, input int s2, input int s3, input int mv,
                               input int md, input int en);
    sample1 = 12'(s1); sample2 = 12'(s2); sample3 = 12'(s3);
    mode_vol = 8'(mv); dac_mode = md[0]; clk_enable = en[0];
    @(posedge clk);
    if (rst_n) modelEdge();
    #1;
    checkOutput("mix_out", int'(mix_out), mixM);
    checkOutput("mix_valid", int'(mix_valid), validM);
    checkOutput("dac_out", int'(dac_out), dacM);
    dacHighs += int'(dac_out);
    validCount += int'(mix_valid);
  endtask

  task automatic randomStep(input int en);
    if ($urandom_range(49) == 0) curMode = 1 - curMode;
    applyStimulus($urandom_range(4095), $urandom_range(4095), $urandom_range(4095),
                  $urandom_range(255), curMode, en);
  endtask

  task automatic doReset();
    rst_n = 1'b0;
    #1;
    checkOutput("rst_mix", int'(mix_out), 0);
    checkOutput("rst_valid", int'(mix_valid), 0);
    checkOutput("rst_dac", int'(dac_out), 0);
    resetModel();
    repeat (2) applyStimulus(0, 0, 0, 0, curMode, 1);
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b1; clk_enable = 1'b0; dac_mode = 1'b0; mode_vol = '0;
    sample1 = '0; sample2 = '0; sample3 = '0;
    resetModel();
    #2;
    doReset();

    // Full-scale voices at full volume, then with voice 3 muted.
    validCount = 0;
    repeat (16) applyStimulus(4095, 4095, 4095, 8'h0F, 0, 1);
    checkOutput("valid_rate", validCount, 4);
    checkOutput("mix_full", int'(mix_out), 'hB3F4);
    repeat (8) applyStimulus(4095, 4095, 4095, 8'h8F, 0, 1);
    checkOutput("mix_3off", int'(mix_out), 'h77F8);

    // 3OFF only matters when present during the voice-3 tick.
    applyStimulus(4095, 4095, 4095, 8'h0F, 0, 1);
    applyStimulus(4095, 4095, 4095, 8'h0F, 0, 1);
    applyStimulus(4095, 4095, 4095, 8'h8F, 0, 1);
    applyStimulus(4095, 4095, 4095, 8'h0F, 0, 1);
    checkOutput("off_in_ph2", int'(mix_out), 'h77F8);
    applyStimulus(4095, 4095, 4095, 8'h8F, 0, 1);
    applyStimulus(4095, 4095, 4095, 8'h8F, 0, 1);
    applyStimulus(4095, 4095, 4095, 8'h0F, 0, 1);
    applyStimulus(4095, 4095, 4095, 8'h8F, 0, 1);
    checkOutput("off_only_ph2", int'(mix_out), 'hB3F4);

    // Volume zero silences both DAC modes.
    repeat (8) applyStimulus($urandom_range(4095), $urandom_range(4095), $urandom_range(4095), 8'h00, 0, 1);
    dacHighs = 0;
    repeat (64) applyStimulus($urandom_range(4095), $urandom_range(4095), $urandom_range(4095), 8'h00, 0, 1);
    checkOutput("vol0_ds_highs", dacHighs, 0);
    checkOutput("vol0_mix", int'(mix_out), 0);
    dacHighs = 0;
    repeat (300) applyStimulus($urandom_range(4095), $urandom_range(4095), $urandom_range(4095), 8'h00, 1, 1);
    checkOutput("vol0_pwm_highs", dacHighs, 0);

    // (4095+4095+2)*8/4 = 0x4000: quarter duty in both modes.
    repeat (16) applyStimulus(4095, 4095, 2, 8'h08, 0, 1);
    checkOutput("mix_quarter", int'(mix_out), 'h4000);
    dacHighs = 0;
    repeat (256) applyStimulus(4095, 4095, 2, 8'h08, 0, 1);
    checkOutput("ds_quarter_highs", dacHighs, 64);
    repeat (4) applyStimulus(4095, 4095, 2, 8'h08, 1, 1);
    dacHighs = 0;
    repeat (256) applyStimulus(4095, 4095, 2, 8'h08, 1, 1);
    checkOutput("pwm_quarter_highs", dacHighs, 64);
    repeat (100) applyStimulus(4095, 4095, 2, 8'h08, 1, 1);
    applyStimulus(4095, 4095, 2, 8'h08, 0, 1);
    checkOutput("mode_switch_dac", int'(dac_out), 0);
    curMode = 0;

    // Async reset landing between voice 2 and voice 3, with gapped enables.
    for (int r = 0; r < 4; r++) begin
      int guard;
      guard = 0;
      while (ticks.size() != 2 && guard < 60) begin
        randomStep(($urandom_range(2) != 0) ? 1 : 0);
        guard++;
      end
      #2;
      doReset();
      repeat (40) randomStep(($urandom_range(2) != 0) ? 1 : 0);
    end

    repeat (1500) randomStep(($urandom_range(3) != 0) ? 1 : 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
